mem_access_sequencer: RTL and testbench

//  Sequences one memory transaction at a time on behalf of the multicycle control FSM; absorbs fixed memory latency.

---
 rtl/mem_access_sequencer_pkg.sv | 12 +
 rtl/mem_access_sequencer_if.sv | 29 ++
 rtl/mem_access_sequencer.sv | 105 ++++++++++
 tb/tb_mem_access_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_sequencer_pkg.sv
// Shared types and constants for the memory access sequencer.
package mem_seq_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, DONE} mseq_state_t;

    localparam logic DEST_IR  = 1'b0;
    localparam logic DEST_MDR = 1'b1;

    localparam int OP_MSB    = 31;
    localparam int OP_LSB    = 26;
    localparam int FUNCT_MSB = 5;
    localparam int FUNCT_LSB = 0;
endpackage

// File: rtl/mem_access_sequencer_if.sv
// Request/response handshake from the control unit plus the memory port of the sequencer.
interface mem_access_sequencer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_wr;
    logic              req_dest;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_ready;
    logic              busy;
    logic              done;
    logic              align_err;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_wr, req_dest, req_addr, req_wdata, mem_rdata,
        output req_ready, busy, done, align_err, mem_addr, mem_wr, mem_wdata
    );

    modport master (
        output req_valid, req_wr, req_dest, req_addr, req_wdata, mem_rdata,
        input  req_ready, busy, done, align_err, mem_addr, mem_wr, mem_wdata
    );
endinterface

// File: rtl/mem_access_sequencer.sv
// One memory transaction at a time: done LATENCY+1 cycles after accept (1 for misaligned).
// Accepts only in IDLE (req_ready); requests while busy are dropped, not queued.
module mem_access_sequencer
    import mem_seq_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    mem_access_sequencer_if.slave bus,
    output logic [DATA_W-1:0] ir_out,
    output logic [DATA_W-1:0] mdr_out,
    output logic [5:0]        Op,
    output logic [5:0]        Funct
);
    localparam int              CNT_W = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LATENCY - 1);

    mseq_state_t       state;
    logic [CNT_W-1:0]  cnt;
    logic              ready_q;
    logic              busy_q;
    logic              done_q;
    logic              align_err_q;
    logic              mem_wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              wr_q;
    logic              dest_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            cnt         <= '0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            align_err_q <= 1'b0;
            mem_wr_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wr_q        <= 1'b0;
            dest_q      <= DEST_IR;
            ir_out      <= '0;
            mdr_out     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        wr_q    <= bus.req_wr;
                        dest_q  <= bus.req_dest;
                        cnt     <= '0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        // Misaligned requests never reach memory; they report straight away.
                        if (bus.req_addr[1:0] == 2'b00) begin
                            state    <= WAIT;
                            mem_wr_q <= bus.req_wr;
                        end else begin
                            state       <= DONE;
                            done_q      <= 1'b1;
                            align_err_q <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    mem_wr_q <= 1'b0;
                    cnt      <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        if (!wr_q) begin
                            if (dest_q == DEST_IR) ir_out  <= bus.mem_rdata;
                            else                   mdr_out <= bus.mem_rdata;
                        end
                        state  <= DONE;
                        done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state       <= IDLE;
                    done_q      <= 1'b0;
                    align_err_q <= 1'b0;
                    busy_q      <= 1'b0;
                    ready_q     <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.req_ready = ready_q;
        bus.busy      = busy_q;
        bus.done      = done_q;
        bus.align_err = align_err_q;
        bus.mem_addr  = addr_q;
        bus.mem_wr    = mem_wr_q;
        bus.mem_wdata = wdata_q;
        Op            = ir_out[OP_MSB:OP_LSB];
        Funct         = ir_out[FUNCT_MSB:FUNCT_LSB];
    end
endmodule

// File: tb/tb_mem_access_sequencer.sv
// Drives a LATENCY=2 and a LATENCY=1 sequencer (one at a time) against a shared memory
// and a transaction-level model of IR/MDR/memory contents.
module tb_mem_access_sequencer;
    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0, req_wr = 1'b0, req_dest = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        load_en = 1'b0;
    logic [7:0]  load_idx = '0;
    logic [31:0] load_dat = '0;
    int          checks = 0, errors = 0, lat = 2;
    logic [31:0] exp_ir = '0, exp_mdr = '0;
    logic [31:0] model_mem [256];
    logic [31:0] mem [256];
    logic [31:0] rdata_a;

    always #5 Clk = ~Clk;

    mem_access_sequencer_if #(.ADDR_W(32), .DATA_W(32)) ifa ();
    mem_access_sequencer_if #(.ADDR_W(32), .DATA_W(32)) ifb ();
    logic [31:0] ir_a, mdr_a, ir_b, mdr_b;
    logic [5:0]  op_a, fn_a, op_b, fn_b;

    mem_access_sequencer #(.LATENCY(2), .ADDR_W(32), .DATA_W(32)) dut_a (
        .Clk(Clk), .Reset(Reset), .bus(ifa), .ir_out(ir_a), .mdr_out(mdr_a), .Op(op_a), .Funct(fn_a));
    mem_access_sequencer #(.LATENCY(1), .ADDR_W(32), .DATA_W(32)) dut_b (
        .Clk(Clk), .Reset(Reset), .bus(ifb), .ir_out(ir_b), .mdr_out(mdr_b), .Op(op_b), .Funct(fn_b));

    assign ifa.req_valid = req_valid & ~sel;
    assign ifb.req_valid = req_valid & sel;
    assign ifa.req_wr = req_wr;     assign ifb.req_wr = req_wr;
    assign ifa.req_dest = req_dest; assign ifb.req_dest = req_dest;
    assign ifa.req_addr = req_addr; assign ifb.req_addr = req_addr;
    assign ifa.req_wdata = req_wdata; assign ifb.req_wdata = req_wdata;

    // Memory: one-stage registered read for LATENCY 2, combinational for LATENCY 1.
    always @(posedge Clk) begin
        if (load_en) mem[load_idx] <= load_dat;
        if (ifa.mem_wr) mem[ifa.mem_addr[9:2]] <= ifa.mem_wdata;
        if (ifb.mem_wr) mem[ifb.mem_addr[9:2]] <= ifb.mem_wdata;
        rdata_a <= mem[ifa.mem_addr[9:2]];
    end
    assign ifa.mem_rdata = rdata_a;
    assign ifb.mem_rdata = mem[ifb.mem_addr[9:2]];

    wire        rdy_s  = sel ? ifb.req_ready : ifa.req_ready;
    wire        busy_s = sel ? ifb.busy      : ifa.busy;
    wire        done_s = sel ? ifb.done      : ifa.done;
    wire        aerr_s = sel ? ifb.align_err : ifa.align_err;
    wire        mwr_s  = sel ? ifb.mem_wr    : ifa.mem_wr;
    wire [31:0] maddr_s = sel ? ifb.mem_addr : ifa.mem_addr;
    wire [31:0] ir_s   = sel ? ir_b  : ir_a;
    wire [31:0] mdr_s  = sel ? mdr_b : mdr_a;
    wire [5:0]  op_s   = sel ? op_b  : op_a;
    wire [5:0]  fn_s   = sel ? fn_b  : fn_a;

    typedef struct {
        logic        wr;
        logic        dest;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_aerr;
        int          exp_pulses;
        logic [31:0] exp_ir;
        logic [31:0] exp_mdr;
    } vec_t;
    vec_t tbl [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (latency %0d): got %h, expected %h", nm, lat, act, exp);
        end
    endtask

    // Entered and left at a negedge with the selected DUT idle.
    task automatic do_txn(input logic wr, input logic dest, input logic [31:0] addr,
                          input logic [31:0] wdata, output int cyc, output int pulses,
                          output logic aerr, output logic addr_ok);
        chk("ready_before_req", {31'b0, rdy_s}, 32'd1);
        req_valid = 1'b1; req_wr = wr; req_dest = dest; req_addr = addr; req_wdata = wdata;
        @(negedge Clk);
        req_valid = 1'b0;
        cyc = 1; pulses = 0; addr_ok = 1'b1;
        while (!done_s && cyc < 20) begin
            if (mwr_s) begin pulses++; if (maddr_s !== addr) addr_ok = 1'b0; end
            @(negedge Clk);
            cyc++;
        end
        if (mwr_s) pulses++;
        aerr = aerr_s;
        @(negedge Clk);
        chk("done_one_cycle", {31'b0, done_s}, 32'd0);
        chk("ready_after_done", {31'b0, rdy_s}, 32'd1);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        @(negedge Clk); @(negedge Clk);
        Reset = 1'b0;
        exp_ir = '0; exp_mdr = '0;
    endtask

    task automatic check_regs(input string tag);
        chk({tag, "_ir"}, ir_s, exp_ir);
        chk({tag, "_mdr"}, mdr_s, exp_mdr);
        chk({tag, "_op"}, {26'b0, op_s}, {26'b0, exp_ir[31:26]});
        chk({tag, "_funct"}, {26'b0, fn_s}, {26'b0, exp_ir[5:0]});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int cyc, pulses, dones, exp_cyc;
        logic aerr, addr_ok, bad_addr, mis;
        logic [7:0] idx;

        tbl[0] = '{1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 0, 32'h012A4020, 32'h0};
        tbl[1] = '{1'b0, 1'b1, 32'h40, 32'h0,        1'b0, 0, 32'h012A4020, 32'hDEADBEEF};
        tbl[2] = '{1'b1, 1'b0, 32'h44, 32'h12345678, 1'b0, 1, 32'h012A4020, 32'hDEADBEEF};
        tbl[3] = '{1'b0, 1'b1, 32'h44, 32'h0,        1'b0, 0, 32'h012A4020, 32'h12345678};
        tbl[4] = '{1'b0, 1'b0, 32'h42, 32'h0,        1'b1, 0, 32'h012A4020, 32'h12345678};
        tbl[5] = '{1'b1, 1'b0, 32'h46, 32'hAAAA5555, 1'b1, 0, 32'h012A4020, 32'h12345678};

        for (int i = 0; i < 256; i++) model_mem[i] = $urandom;
        model_mem[0]  = 32'h012A4020;
        model_mem[16] = 32'hDEADBEEF;

        // Preload memory while both DUTs sit in reset.
        Reset = 1'b1;
        @(negedge Clk);
        for (int i = 0; i < 256; i++) begin
            load_en = 1'b1; load_idx = i[7:0]; load_dat = model_mem[i];
            @(negedge Clk);
        end
        load_en = 1'b0;
        for (int s = 0; s < 2; s++) begin
            sel = (s == 1); lat = (s == 1) ? 1 : 2;
            chk("rst_ready", {31'b0, rdy_s}, 32'd1);
            chk("rst_busy", {31'b0, busy_s}, 32'd0);
            chk("rst_done", {31'b0, done_s}, 32'd0);
            chk("rst_align_err", {31'b0, aerr_s}, 32'd0);
            chk("rst_mem_wr", {31'b0, mwr_s}, 32'd0);
            chk("rst_mem_addr", maddr_s, 32'h0);
            chk("rst_ir", ir_s, 32'h0);
            chk("rst_mdr", mdr_s, 32'h0);
        end
        Reset = 1'b0;

        for (int p = 0; p < 2; p++) begin
            sel = (p == 1); lat = (p == 1) ? 1 : 2;
            do_reset();

            // Directed vectors.
            for (int v = 0; v < 6; v++) begin
                do_txn(tbl[v].wr, tbl[v].dest, tbl[v].addr, tbl[v].wdata, cyc, pulses, aerr, addr_ok);
                exp_cyc = tbl[v].exp_aerr ? 1 : lat + 1;
                chk("vec_done_cycle", cyc, exp_cyc);
                chk("vec_align_err", {31'b0, aerr}, {31'b0, tbl[v].exp_aerr});
                chk("vec_wr_pulses", pulses, tbl[v].exp_pulses);
                chk("vec_wr_addr", {31'b0, addr_ok}, 32'd1);
                exp_ir = tbl[v].exp_ir; exp_mdr = tbl[v].exp_mdr;
                check_regs("vec");
            end
            model_mem[17] = 32'h12345678;

            // Randomized transactions against the transaction-level model.
            for (int n = 0; n < 40; n++) begin
                logic w, d;
                logic [31:0] a, wd;
                w = $urandom_range(0, 1) == 1;
                d = $urandom_range(0, 1) == 1;
                idx = 8'($urandom_range(32, 63));
                mis = $urandom_range(0, 3) == 0;
                a = {22'b0, idx, (mis ? 2'($urandom_range(1, 3)) : 2'b00)};
                wd = $urandom;
                do_txn(w, d, a, wd, cyc, pulses, aerr, addr_ok);
                if (!mis) begin
                    if (w) model_mem[idx] = wd;
                    else if (d) exp_mdr = model_mem[idx];
                    else exp_ir = model_mem[idx];
                end
                chk("rnd_done_cycle", cyc, mis ? 1 : lat + 1);
                chk("rnd_align_err", {31'b0, aerr}, {31'b0, mis});
                chk("rnd_wr_pulses", pulses, (w && !mis) ? 1 : 0);
                chk("rnd_wr_addr", {31'b0, addr_ok}, 32'd1);
                check_regs("rnd");
                repeat ($urandom_range(0, 2)) @(negedge Clk);
            end
            for (int i = 32; i < 64; i++) chk("rnd_mem_contents", mem[i], model_mem[i]);

            // Request pulsed while a read is in flight must be ignored.
            req_valid = 1'b1; req_wr = 1'b0; req_dest = 1'b1; req_addr = 32'h40; req_wdata = '0;
            @(negedge Clk);
            req_addr = 32'h80; req_dest = 1'b0;
            chk("busy_inflight_addr", maddr_s, 32'h40);
            chk("busy_ready_low", {31'b0, rdy_s}, 32'd0);
            dones = done_s ? 1 : 0;
            bad_addr = 1'b0;
            @(negedge Clk);
            req_valid = 1'b0;
            for (int k = 0; k < 8; k++) begin
                if (done_s) dones++;
                if (busy_s && maddr_s !== 32'h40) bad_addr = 1'b1;
                @(negedge Clk);
            end
            exp_mdr = model_mem[16];
            chk("busy_done_count", dones, 1);
            chk("busy_addr_stable", {31'b0, bad_addr}, 32'd0);
            check_regs("busy");

            // Reset in the first WAIT cycle of a write aborts the transaction.
            req_valid = 1'b1; req_wr = 1'b1; req_dest = 1'b0; req_addr = 32'h200; req_wdata = 32'hCAFEF00D;
            @(negedge Clk);
            req_valid = 1'b0;
            pulses = mwr_s ? 1 : 0;
            Reset = 1'b1;
            @(negedge Clk);
            exp_ir = '0; exp_mdr = '0;
            chk("abort_ready", {31'b0, rdy_s}, 32'd1);
            chk("abort_busy", {31'b0, busy_s}, 32'd0);
            chk("abort_mem_wr", {31'b0, mwr_s}, 32'd0);
            check_regs("abort");
            Reset = 1'b0;
            dones = 0;
            for (int k = 0; k < 5; k++) begin
                if (done_s) dones++;
                if (mwr_s) pulses++;
                @(negedge Clk);
            end
            chk("abort_no_done", dones, 0);
            chk("abort_wr_pulses_le1", {31'b0, pulses <= 1}, 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
